// File: rtl/gpu_writeback_unit_pkg.sv
// Shared types and constants for the GPU writeback unit and its load-return FIFO.
// Optional feature macro used by the top level: WB_BYPASS_EN.
package gpu_writeback_unit_pkg;

  localparam int         NUM_REGS = 16;
  localparam int         DATA_W   = 64;
  localparam logic [3:0] REG_ZERO = 4'hF;

  typedef struct packed {
    logic [3:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous load-return FIFO with registered storage and an occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_sync_fifo
  import gpu_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  wb_entry_t        wdata_i,
  output wb_entry_t        rdata_o,
  output logic             full_o,
  output logic [PTR_W:0]   count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gpu_writeback_unit.sv
// Writeback arbiter (ALU over load returns) with a register scoreboard and issue stall.
// Define WB_BYPASS_EN to add the writeback-to-issue bypass ports.
module gpu_writeback_unit
  import gpu_writeback_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [3:0]          issue_rs1,
  input  logic [3:0]          issue_rs2,
  input  logic [3:0]          issue_rd,
  input  logic                issue_wr,
  output logic                stall,
  input  logic                alu_valid,
  input  logic [3:0]          alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [3:0]          mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                rf_we,
  output logic [3:0]          rf_rd_addr,
  output logic [DATA_W-1:0]   rf_rd_data,
  output logic [NUM_REGS-1:0] pending
`ifdef WB_BYPASS_EN
  ,
  output logic                byp_rs1_hit,
  output logic                byp_rs2_hit,
  output logic [DATA_W-1:0]   byp_rs1_data,
  output logic [DATA_W-1:0]   byp_rs2_data
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                rf_we_q, rf_we_d;
  logic [3:0]          rf_rd_addr_q, rf_rd_addr_d;
  logic [DATA_W-1:0]   rf_rd_data_q, rf_rd_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  wb_entry_t           fifo_wdata, fifo_head;
  logic                fifo_full, fifo_pop;
  logic [CNT_W-1:0]    fifo_count;
  logic                rs1_busy, rs2_busy, issue_fire;

  assign fifo_wdata = '{rd: mem_rd, data: mem_data};
  assign mem_ready  = !fifo_full;
  assign fifo_pop   = !alu_valid && (fifo_count != '0);

  wb_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_load_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (mem_valid),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

`ifdef WB_BYPASS_EN
  // A source being written back this cycle is forwarded, so its pending bit no longer blocks issue.
  assign byp_rs1_hit  = rf_we_q && (rf_rd_addr_q == issue_rs1) && (rf_rd_addr_q != REG_ZERO);
  assign byp_rs2_hit  = rf_we_q && (rf_rd_addr_q == issue_rs2) && (rf_rd_addr_q != REG_ZERO);
  assign byp_rs1_data = rf_rd_data_q;
  assign byp_rs2_data = rf_rd_data_q;
  assign rs1_busy     = pending_q[issue_rs1] && !byp_rs1_hit;
  assign rs2_busy     = pending_q[issue_rs2] && !byp_rs2_hit;
`else
  assign rs1_busy     = pending_q[issue_rs1];
  assign rs2_busy     = pending_q[issue_rs2];
`endif

  assign stall      = issue_valid && (rs1_busy || rs2_busy || (issue_wr && pending_q[issue_rd]));
  assign issue_fire = issue_valid && !stall;

  // Results to r15 are consumed silently; address/data keep their last written values.
  always_comb begin
    rf_we_d      = 1'b0;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_rd_data_d = rf_rd_data_q;
    if (alu_valid) begin
      if (alu_rd != REG_ZERO) begin
        rf_we_d      = 1'b1;
        rf_rd_addr_d = alu_rd;
        rf_rd_data_d = alu_data;
      end
    end else if (fifo_pop) begin
      if (fifo_head.rd != REG_ZERO) begin
        rf_we_d      = 1'b1;
        rf_rd_addr_d = fifo_head.rd;
        rf_rd_data_d = fifo_head.data;
      end
    end
  end

  // Set is applied after clear so a same-cycle issue to the retiring register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) pending_d[rf_rd_addr_q] = 1'b0;
    if (issue_fire && issue_wr && (issue_rd != REG_ZERO)) pending_d[issue_rd] = 1'b1;
    pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q      <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_rd_data_q <= '0;
      pending_q    <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_rd_data_q <= rf_rd_data_d;
      pending_q    <= pending_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_rd_data = rf_rd_data_q;
  assign pending    = pending_q;

endmodule
